// File: rtl/activation_unit_pkg.sv
// Shared types for the activation unit: element type, activation modes and FSM states.
package types;

  localparam int DATA_TYPE_SIZE = 8;

  typedef logic signed [DATA_TYPE_SIZE-1:0] data_type;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    RELU   = 2'b01,
    LEAKY  = 2'b10,
    CLAMP  = 2'b11
  } act_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PROC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/activation_unit_if.sv
// Vector handshake bundle between a producer/consumer (master) and the activation unit (slave).
interface activation_unit_if
  import types::*;
#(
  parameter int IN_SIZE = 16
);

  act_mode_t mode_i;
  data_type  clamp_max_i;
  logic      in_valid_i;
  logic      in_ready_o;
  data_type  data_i [0:IN_SIZE-1];
  logic      out_valid_o;
  logic      out_ready_i;
  data_type  data_o [0:IN_SIZE-1];
  logic      busy_o;

  modport master (
    output mode_i, clamp_max_i, in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, busy_o
  );

  modport slave (
    input  mode_i, clamp_max_i, in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, busy_o
  );

endinterface

// File: rtl/activation_unit_act_lane.sv
// Single-element activation function; purely combinational.
module act_lane
  import types::*;
#(
  parameter int LEAK_SHIFT = 3
) (
  input  act_mode_t mode,
  input  data_type  clamp_max,
  input  data_type  x,
  output data_type  y
);

  data_type bound;
  logic     x_neg;

  assign x_neg = x[DATA_TYPE_SIZE-1];

  // Select the activation; a negative clamp bound collapses to zero.
  // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    bound = clamp_max[DATA_TYPE_SIZE-1] ? '0 : clamp_max;
    y     = x;
    case (mode)
      BYPASS: y = x;
      RELU:   y = x_neg ? '0 : x;
      LEAKY:  y = x_neg ? data_type'(x >>> LEAK_SHIFT) : x;
      CLAMP: begin
        if (x_neg)          y = '0;
        else if (x > bound) y = bound;
        else                y = x;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Activation unit: captures a vector, processes LANES elements per beat, then
// presents the result until the consumer accepts it.
module activation_unit
  import types::*;
#(
  parameter int IN_SIZE    = 16,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  activation_unit_if.slave bus
);

  localparam int BEATS = IN_SIZE / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q;
  act_mode_t       mode_q;
  data_type        clamp_q;
  data_type        data_q [0:IN_SIZE-1];
  data_type        out_q  [0:IN_SIZE-1];
  logic            in_ready, out_valid, busy;
  logic            accept, last_beat;
  logic [IW-1:0]   idx    [0:LANES-1];
  data_type        lane_x [0:LANES-1];
  data_type        lane_y [0:LANES-1];

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign accept    = bus.in_valid_i && in_ready;

  // One lane instance per element processed in a beat.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign idx[l]    = IW'(int'(beat_q) * LANES + l);
    assign lane_x[l] = data_q[idx[l]];

    act_lane #(.LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .mode      (mode_q),
      .clamp_max (clamp_q),
      .x         (lane_x[l]),
      .y         (lane_y[l])
    );
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake outputs; input is refused while reset is held.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        in_ready = rst_ni;
        if (bus.in_valid_i && rst_ni) state_d = PROC;
      end
      PROC: begin
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready_i;
        if (bus.out_ready_i) state_d = bus.in_valid_i ? PROC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on accept, then step through the beats writing results.
  // NOTE: the vector registers are reset too because zeroed data_o after reset is observable behaviour.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      mode_q  <= BYPASS;
      clamp_q <= '0;
      for (int i = 0; i < IN_SIZE; i++) begin
        data_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else if (accept) begin
      beat_q  <= '0;
      mode_q  <= bus.mode_i;
      clamp_q <= bus.clamp_max_i;
      data_q  <= bus.data_i;
    end else if (state_q == PROC) begin
      beat_q <= last_beat ? '0 : beat_q + 1'b1;
      for (int l = 0; l < LANES; l++) out_q[idx[l]] <= lane_y[l];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.busy_o      = busy;
  assign bus.data_o      = out_q;

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit with hand-computed expected vectors.
module tb_activation_unit;
  import types::*;

  localparam int IN_SIZE = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  activation_unit_if #(.IN_SIZE(IN_SIZE)) bus ();

  activation_unit #(
    .IN_SIZE    (IN_SIZE),
    .LANES      (4),
    .LEAK_SHIFT (3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Wait for in_ready (bounded), take the accepting edge, drop in_valid.
  task automatic do_accept();
    int n = 0;
    while (!bus.in_ready_o && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  // Count cycles until out_valid rises (bounded) and compare with the expected latency.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!bus.out_valid_o && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check(tag, n, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode_i      = BYPASS;
    bus.clamp_max_i = '0;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < IN_SIZE; k++) bus.data_i[k] = data_type'(k + 1);

    // Reset state, with in_valid high to show nothing is taken.
    #12;
    check("rst_in_ready", bus.in_ready_o, 0);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_data0", bus.data_o[0], 0);
    check("rst_data15", bus.data_o[15], 0);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;

    // RELU: data[k] = k-8.
    bus.mode_i = RELU;
    for (int k = 0; k < IN_SIZE; k++) bus.data_i[k] = data_type'(k - 8);
    bus.in_valid_i = 1'b1;
    do_accept();
    check("relu_busy", bus.busy_o, 1);
    wait_valid("relu_latency", 4);
    for (int k = 0; k < IN_SIZE; k++) check($sformatf("relu_d%0d", k), bus.data_o[k], (k < 8) ? 0 : k - 8);
    check("relu_done_in_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;
    check("relu_idle_valid", bus.out_valid_o, 0);
    check("relu_idle_busy", bus.busy_o, 0);

    // LEAKY with mode changed to BYPASS right after accept.
    bus.mode_i = LEAKY;
    bus.data_i[0] = -8'sd1;
    bus.data_i[1] = -8'sd8;
    bus.data_i[2] = -8'sd9;
    bus.data_i[3] = 8'sd100;
    for (int k = 4; k < IN_SIZE; k++) bus.data_i[k] = -8'sd16;
    bus.in_valid_i = 1'b1;
    do_accept();
    bus.mode_i = BYPASS;
    @(posedge clk); #1;
    check("leaky_b0_d0", bus.data_o[0], -1);
    check("leaky_b0_d3", bus.data_o[3], 100);
    check("leaky_keep_d12", bus.data_o[12], 4);
    check("leaky_b0_valid", bus.out_valid_o, 0);
    wait_valid("leaky_latency", 3);
    check("leaky_d0", bus.data_o[0], -1);
    check("leaky_d1", bus.data_o[1], -1);
    check("leaky_d2", bus.data_o[2], -2);
    check("leaky_d3", bus.data_o[3], 100);
    check("leaky_d12", bus.data_o[12], -2);
    @(posedge clk); #1;

    // CLAMP 6 with backpressure in DONE.
    bus.mode_i      = CLAMP;
    bus.clamp_max_i = 8'sd6;
    bus.data_i[0] = -8'sd3;
    bus.data_i[1] = 8'sd0;
    bus.data_i[2] = 8'sd6;
    bus.data_i[3] = 8'sd7;
    bus.data_i[4] = 8'sd127;
    for (int k = 5; k < IN_SIZE; k++) bus.data_i[k] = 8'sd3;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    do_accept();
    bus.clamp_max_i = 8'sd1;
    wait_valid("clamp_latency", 4);
    check("clamp_d0", bus.data_o[0], 0);
    check("clamp_d1", bus.data_o[1], 0);
    check("clamp_d2", bus.data_o[2], 6);
    check("clamp_d3", bus.data_o[3], 6);
    check("clamp_d4", bus.data_o[4], 6);
    check("clamp_d5", bus.data_o[5], 3);
    for (int c = 0; c < 10; c++) begin
      check("bp_in_ready", bus.in_ready_o, 0);
      check("bp_valid", bus.out_valid_o, 1);
      check("bp_d3", bus.data_o[3], 6);
      check("bp_d4", bus.data_o[4], 6);
      @(posedge clk); #1;
    end

    // Back-to-back: release output and offer CLAMP with negative bound.
    bus.clamp_max_i = -8'sd5;
    for (int k = 0; k < IN_SIZE; k++) bus.data_i[k] = 8'sd4;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    #1;
    check("b2b_in_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check("b2b_valid_drop", bus.out_valid_o, 0);
    check("b2b_busy", bus.busy_o, 1);
    wait_valid("b2b_latency", 4);
    check("negclamp_d0", bus.data_o[0], 0);
    check("negclamp_d15", bus.data_o[15], 0);
    @(posedge clk); #1;

    // BYPASS extremes.
    bus.mode_i = BYPASS;
    for (int k = 0; k < IN_SIZE; k++) bus.data_i[k] = data_type'(k);
    bus.data_i[0] = -8'sd128;
    bus.data_i[1] = 8'sd127;
    bus.data_i[2] = -8'sd5;
    bus.in_valid_i = 1'b1;
    do_accept();
    wait_valid("bypass_latency", 4);
    check("bypass_d0", bus.data_o[0], -128);
    check("bypass_d1", bus.data_o[1], 127);
    check("bypass_d2", bus.data_o[2], -5);
    check("bypass_d15", bus.data_o[15], 15);
    @(posedge clk); #1;

    // Reset asserted mid-clock while beat 2 is current.
    bus.mode_i = RELU;
    for (int k = 0; k < IN_SIZE; k++) bus.data_i[k] = 8'sd5;
    bus.in_valid_i = 1'b1;
    do_accept();
    @(posedge clk); #1;
    check("pre_rst_d0", bus.data_o[0], 5);
    @(posedge clk); #4;
    rst_n = 1'b0;
    #1;
    check("mid_rst_d0", bus.data_o[0], 0);
    check("mid_rst_d15", bus.data_o[15], 0);
    check("mid_rst_valid", bus.out_valid_o, 0);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_in_ready", bus.in_ready_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready_o, 1);
    check("post_rst_busy", bus.busy_o, 0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", bus.out_valid_o, 0);
    end
    check("post_rst_in_ready2", bus.in_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
